colour_fader: RTL and testbench

COLOUR_FADER -- requirements
Module: colour_fader

---
 rtl/colour_fader.sv | 121 ++++++++++++
 tb/tb_colour_fader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/colour_fader.sv
// colour_fader: fades a registered RGB colour one step per prescaler tick toward a
// requested target, dwells on the target for a number of ticks, then pulses done.
//
// Ports:
//   clock_100mhz  in   single clock, rising edge
//   reset         in   synchronous, active-high
//   target_valid  in   requester presents a new target colour
//   target_ready  out  block can accept a target this cycle (IDLE and not in reset)
//   target_red/green/blue  in  8-bit target colour, sampled on handshake only
//   red/green/blue         out 8-bit current colour, registered
//   busy          out  high whenever not IDLE
//   done          out  one-cycle pulse in the first IDLE cycle after HOLD
module colour_fader #(
    parameter int unsigned TICK_CYCLES = 1000,
    parameter int unsigned HOLD_TICKS  = 256
) (
    input  logic       clock_100mhz,
    input  logic       reset,
    input  logic       target_valid,
    output logic       target_ready,
    input  logic [7:0] target_red,
    input  logic [7:0] target_green,
    input  logic [7:0] target_blue,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       busy,
    output logic       done
);

    localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    // Unused when HOLD_TICKS is 0; kept in range so the comparison stays well-formed.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);

    typedef enum logic [1:0] {StIdle, StFade, StHold} state_t;

    state_t            state;
    logic [TICK_W-1:0] tick_count;
    logic [HOLD_W-1:0] hold_count;
    logic [7:0]        tgt_red;
    logic [7:0]        tgt_green;
    logic [7:0]        tgt_blue;
    logic              tick;
    logic              at_target;

    // One unit toward the target; equal channels stay put, so no wrap is possible.
    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt) begin
            return cur + 8'd1;
        end else if (cur > tgt) begin
            return cur - 8'd1;
        end
        return cur;
    endfunction

    assign tick         = (tick_count == TICK_LAST);
    assign at_target    = (red == tgt_red) && (green == tgt_green) && (blue == tgt_blue);
    assign busy         = (state != StIdle);
    assign target_ready = (state == StIdle) && !reset;

    always_ff @(posedge clock_100mhz) begin
        if (reset) begin
            state      <= StIdle;
            tick_count <= '0;
            hold_count <= '0;
            tgt_red    <= 8'd0;
            tgt_green  <= 8'd0;
            tgt_blue   <= 8'd0;
            red        <= 8'd0;
            green      <= 8'd0;
            blue       <= 8'd0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (target_valid) begin
                        tgt_red    <= target_red;
                        tgt_green  <= target_green;
                        tgt_blue   <= target_blue;
                        tick_count <= '0;
                        state      <= StFade;
                    end
                end
                StFade: begin
                    // Arrival is checked every cycle, not only on ticks.
                    if (at_target) begin
                        tick_count <= '0;
                        hold_count <= '0;
                        state      <= StHold;
                    end else begin
                        tick_count <= tick ? '0 : tick_count + 1'b1;
                        if (tick) begin
                            red   <= step_toward(red, tgt_red);
                            green <= step_toward(green, tgt_green);
                            blue  <= step_toward(blue, tgt_blue);
                        end
                    end
                end
                StHold: begin
                    tick_count <= tick ? '0 : tick_count + 1'b1;
                    if (HOLD_TICKS == 0) begin
                        state <= StIdle;
                        done  <= 1'b1;
                    end else if (tick) begin
                        if (hold_count == HOLD_LAST) begin
                            state <= StIdle;
                            done  <= 1'b1;
                        end else begin
                            hold_count <= hold_count + 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_colour_fader.sv
module tb_colour_fader;

    localparam int TC = 4;
    localparam int HT = 2;

    logic       clk;
    logic       reset;
    logic       target_valid;
    logic       target_ready;
    logic [7:0] target_red;
    logic [7:0] target_green;
    logic [7:0] target_blue;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    // Model state: colour the DUT currently shows between sequences.
    int cur_r, cur_g, cur_b;

    colour_fader #(
        .TICK_CYCLES(TC),
        .HOLD_TICKS (HT)
    ) dut (
        .clock_100mhz(clk),
        .reset       (reset),
        .target_valid(target_valid),
        .target_ready(target_ready),
        .target_red  (target_red),
        .target_green(target_green),
        .target_blue (target_blue),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Channel value after n ticks of fading from s toward t.
    function automatic int chan_after(input int s, input int t, input int n);
        if (t > s) return s + imin(n, t - s);
        return s - imin(n, s - t);
    endfunction

    // Whole-output expectation k edges after the handshake edge, from closed-form timing:
    // D ticks of fade, arrival seen one edge later, HT*TC cycles of hold, then done.
    function automatic logic [26:0] expect_at(input int sr, input int sg, input int sb,
                                              input int tr, input int tg, input int tb,
                                              input int k);
        int d, last, n;
        logic b, dn;
        d    = iabs(tr - sr);
        d    = (iabs(tg - sg) > d) ? iabs(tg - sg) : d;
        d    = (iabs(tb - sb) > d) ? iabs(tb - sb) : d;
        last = TC * d + 1 + TC * HT;
        n    = k / TC;
        b    = (k < last);
        dn   = (k == last);
        return {8'(chan_after(sr, tr, n)), 8'(chan_after(sg, tg, n)), 8'(chan_after(sb, tb, n)),
                b, dn, !b};
    endfunction

    function automatic int seq_len(input int tr, input int tg, input int tb);
        int d;
        d = iabs(tr - cur_r);
        d = (iabs(tg - cur_g) > d) ? iabs(tg - cur_g) : d;
        d = (iabs(tb - cur_b) > d) ? iabs(tb - cur_b) : d;
        return TC * d + 1 + TC * HT;
    endfunction

    task automatic check(input string tag, input int k, input logic [26:0] exp_v);
        logic [26:0] obs;
        obs = {red, green, blue, busy, done, target_ready};
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s k=%0d observed rgb=%h_%h_%h busy/done/ready=%b expected rgb=%h_%h_%h busy/done/ready=%b",
                   tag, k, obs[26:19], obs[18:11], obs[10:3], obs[2:0],
                   exp_v[26:19], exp_v[18:11], exp_v[10:3], exp_v[2:0]);
        end
    endtask

    task automatic present(input int r, input int g, input int b);
        target_valid = 1'b1;
        target_red   = 8'(r);
        target_green = 8'(g);
        target_blue  = 8'(b);
    endtask

    // Assumes the target is presented and the DUT is ready. When keep is set, the next
    // target stays asserted through the fade so it is taken in the done cycle.
    task automatic run_seq(input string tag, input int tr, input int tg, input int tb,
                           input bit keep, input int nr, input int ng, input int nb);
        int last;
        last = seq_len(tr, tg, tb);
        @(posedge clk); #1;
        if (keep) present(nr, ng, nb);
        else target_valid = 1'b0;
        for (int k = 0; k <= last; k++) begin
            check(tag, k, expect_at(cur_r, cur_g, cur_b, tr, tg, tb, k));
            if (k < last) begin
                @(posedge clk); #1;
            end
        end
        cur_r = tr; cur_g = tg; cur_b = tb;
        if (!keep) begin
            @(posedge clk); #1;
            check({tag, "_idle"}, last + 1, {8'(cur_r), 8'(cur_g), 8'(cur_b), 3'b001});
        end
    endtask

    initial begin
        reset        = 1'b1;
        target_valid = 1'b0;
        target_red   = 8'd0;
        target_green = 8'd0;
        target_blue  = 8'd0;
        cur_r = 0; cur_g = 0; cur_b = 0;

        // Reset state: ready must stay low while reset is high.
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 0, 27'b000);
        reset = 1'b0;
        @(posedge clk); #1;
        check("reset_release", 0, 27'b001);

        // Long fade from black; blue arrives at tick 128.
        present(8'h40, 8'h60, 8'h80);
        run_seq("fade_406080", 8'h40, 8'h60, 8'h80, 1'b0, 0, 0, 0);

        // Small downward step on one channel.
        present(8'h80, 8'h80, 8'h80);
        run_seq("to_808080", 8'h80, 8'h80, 8'h80, 1'b0, 0, 0, 0);
        present(8'h7E, 8'h80, 8'h80);
        run_seq("down_7e", 8'h7E, 8'h80, 8'h80, 1'b0, 0, 0, 0);

        // Target equal to current colour: one FADE cycle then hold.
        present(8'h7E, 8'h80, 8'h80);
        run_seq("same_colour", 8'h7E, 8'h80, 8'h80, 1'b0, 0, 0, 0);

        // White requested mid-fade is ignored until the done cycle, then taken back-to-back.
        present(8'h70, 8'h90, 8'h88);
        run_seq("ignore_busy", 8'h70, 8'h90, 8'h88, 1'b1, 8'hFF, 8'hFF, 8'hFF);
        run_seq("back_to_back", 8'hFF, 8'hFF, 8'hFF, 1'b0, 0, 0, 0);

        // Fade down to 0x80 aborted by reset at tick 10.
        present(8'h80, 8'h80, 8'h80);
        @(posedge clk); #1;
        target_valid = 1'b0;
        for (int k = 0; k <= 10 * TC; k++) begin
            check("abort_fade", k, expect_at(cur_r, cur_g, cur_b, 8'h80, 8'h80, 8'h80, k));
            if (k < 10 * TC) begin
                @(posedge clk); #1;
            end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_reset", 0, 27'b000);
        reset = 1'b0;
        cur_r = 0; cur_g = 0; cur_b = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            check("abort_after", k, 27'b001);
        end

        // Randomised targets from wherever the previous sequence left off.
        for (int i = 0; i < 6; i++) begin
            int r, g, b;
            r = int'($urandom_range(255, 0));
            g = int'($urandom_range(255, 0));
            b = int'($urandom_range(255, 0));
            present(r, g, b);
            run_seq("random", r, g, b, 1'b0, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
